lvl_request_queue: RTL and testbench

LVL_REQUEST_QUEUE -- requirements
Module: lvl_request_queue

---
 rtl/lvl_request_queue.sv | 115 +++++++++++
 tb/tb_lvl_request_queue.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/lvl_request_queue.sv
// Level-request queue for a four-level car: 4-entry FIFO of pressed levels plus a
// seek/door controller that serves the head entry and dequeues it when the door closes.
module lvl_request_queue #(
    parameter int unsigned DOOR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_valid,
    input  logic [1:0] pressed_lvl,
    input  logic       pressed_lvl_in_queue,
    input  logic       arrive,
    output logic [7:0] queue,
    output logic [2:0] tail,
    output logic       target_valid,
    output logic [1:0] target_lvl,
    output logic       door_open,
    output logic       enq_drop
);

    typedef enum logic [1:0] {StIdle, StSeek, StDoor} state_e;

    localparam logic [3:0] DoorLoad = 4'(DOOR_CYCLES - 1);

    state_e     state_q;
    logic [3:0] door_cnt_q;
    logic [7:0] queue_q, queue_d;
    logic [2:0] tail_q, tail_d;
    logic       enq_drop_q;
    logic       target_valid_q;
    logic       door_open_q;
    logic       deq;
    logic       enq_ok;

    assign deq    = (state_q == StDoor) && (door_cnt_q == 4'd0);
    assign enq_ok = btn_valid && !pressed_lvl_in_queue && ((tail_q < 3'd4) || deq);

    // Shift first, then append at the (possibly reduced) tail; covers enqueue-on-full.
    always_comb begin
        queue_d = queue_q;
        tail_d  = tail_q;
        if (deq) begin
            queue_d = {2'b00, queue_q[7:2]};
            tail_d  = tail_q - 3'd1;
        end
        if (enq_ok) begin
            queue_d[{tail_d[1:0], 1'b0} +: 2] = pressed_lvl;
            tail_d = tail_d + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            queue_q    <= 8'd0;
            tail_q     <= 3'd0;
            enq_drop_q <= 1'b0;
        end else begin
            queue_q    <= queue_d;
            tail_q     <= tail_d;
            enq_drop_q <= btn_valid && !enq_ok;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= StIdle;
            door_cnt_q     <= 4'd0;
            target_valid_q <= 1'b0;
            door_open_q    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (tail_q != 3'd0) begin
                        state_q        <= StSeek;
                        target_valid_q <= 1'b1;
                    end
                end
                StSeek: begin
                    if (arrive) begin
                        state_q        <= StDoor;
                        door_cnt_q     <= DoorLoad;
                        target_valid_q <= 1'b0;
                        door_open_q    <= 1'b1;
                    end
                end
                StDoor: begin
                    if (door_cnt_q != 4'd0) begin
                        door_cnt_q <= door_cnt_q - 4'd1;
                    end else begin
                        door_open_q <= 1'b0;
                        // Decide on the tail after this cycle's dequeue/enqueue.
                        if (tail_d != 3'd0) begin
                            state_q        <= StSeek;
                            target_valid_q <= 1'b1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: begin
                    state_q        <= StIdle;
                    target_valid_q <= 1'b0;
                    door_open_q    <= 1'b0;
                end
            endcase
        end
    end

    assign queue        = queue_q;
    assign tail         = tail_q;
    assign target_valid = target_valid_q;
    assign target_lvl   = queue_q[1:0];
    assign door_open    = door_open_q;
    assign enq_drop     = enq_drop_q;

endmodule

// File: tb/tb_lvl_request_queue.sv
// Bench for lvl_request_queue: directed vector table, door-timing and reset sequences,
// then random traffic against a queue-based reference model.
module tb_lvl_request_queue;

    localparam int unsigned DC = 4;

    logic       clk = 1'b0;
    logic       rst, btn_valid, dup, arrive;
    logic [1:0] pressed_lvl;
    logic [7:0] queue;
    logic [2:0] tail;
    logic       target_valid, door_open, enq_drop;
    logic [1:0] target_lvl;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lvl_request_queue #(.DOOR_CYCLES(DC)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .btn_valid           (btn_valid),
        .pressed_lvl         (pressed_lvl),
        .pressed_lvl_in_queue(dup),
        .arrive              (arrive),
        .queue               (queue),
        .tail                (tail),
        .target_valid        (target_valid),
        .target_lvl          (target_lvl),
        .door_open           (door_open),
        .enq_drop            (enq_drop)
    );

    typedef struct {
        logic       r;
        logic       b;
        logic [1:0] l;
        logic       d;
        logic       a;
        logic [7:0] q;
        logic [2:0] t;
        logic       tv;
        logic [1:0] tl;
        logic       door;
        logic       drop;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] q, input logic [2:0] t,
                           input logic tv, input logic [1:0] tl, input logic dr,
                           input logic drop);
        chk($sformatf("%s.queue", tag), int'(queue), int'(q));
        chk($sformatf("%s.tail", tag), int'(tail), int'(t));
        chk($sformatf("%s.target_valid", tag), int'(target_valid), int'(tv));
        chk($sformatf("%s.target_lvl", tag), int'(target_lvl), int'(tl));
        chk($sformatf("%s.door_open", tag), int'(door_open), int'(dr));
        chk($sformatf("%s.enq_drop", tag), int'(enq_drop), int'(drop));
    endtask

    task automatic drive(input logic r, input logic b, input logic [1:0] l, input logic d,
                         input logic a);
        rst         = r;
        btn_valid   = b;
        pressed_lvl = l;
        dup         = d;
        arrive      = a;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference model state: plain list of pending levels plus a mode and door countdown.
    int mq[$];
    int mode;     // 0 idle, 1 seeking, 2 door open
    int left;
    logic mdrop;

    task automatic model_step(input logic r, input logic b, input logic [1:0] l,
                              input logic d, input logic a);
        bit deq_m, ok;
        int pre;
        if (r) begin
            mq.delete();
            mode  = 0;
            left  = 0;
            mdrop = 1'b0;
            return;
        end
        pre   = mq.size();
        deq_m = (mode == 2) && (left == 0);
        ok    = b && !d && (pre < 4 || deq_m);
        mdrop = b && !ok;
        if (deq_m) void'(mq.pop_front());
        if (ok) mq.push_back(int'(l));
        case (mode)
            0: if (pre != 0) mode = 1;
            1: if (a) begin mode = 2; left = int'(DC) - 1; end
            default: begin
                if (left != 0) left--;
                else mode = (mq.size() != 0) ? 1 : 0;
            end
        endcase
    endtask

    task automatic model_check(input string tag);
        logic [7:0] q;
        q = 8'd0;
        foreach (mq[i]) q[2*i +: 2] = 2'(mq[i]);
        chk_all(tag, q, 3'(mq.size()), mode == 1, (mq.size() != 0) ? 2'(mq[0]) : 2'd0,
                mode == 2, mdrop);
    endtask

    initial begin
        int ncyc;
        // r b l d a | q t tv tl door drop
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h02, 3'd1, 1'b0, 2'd2, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 8'h02, 3'd2, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 8'h32, 3'd3, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h72, 3'd4, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 8'h72, 3'd4, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h72, 3'd4, 1'b1, 2'd2, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 8'h72, 3'd4, 1'b1, 2'd2, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h72, 3'd4, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h72, 3'd4, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h72, 3'd4, 1'b0, 2'd2, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 8'h72, 3'd4, 1'b0, 2'd2, 1'b1, 1'b0};
        // Dequeue on a full queue with a same-cycle press: shift, then write 2 at index 3.
        vecs[12] = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 8'h9C, 3'd4, 1'b1, 2'd0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h9C, 3'd4, 1'b0, 2'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 2'd1, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0};

        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].r, vecs[i].b, vecs[i].l, vecs[i].d, vecs[i].a);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].q, vecs[i].t, vecs[i].tv, vecs[i].tl,
                    vecs[i].door, vecs[i].drop);
        end

        // Door timing: queue 1,3, arrive from SEEK, door open exactly DC cycles.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        chk("seek_reached", int'(target_valid), 1);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1); tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
        ncyc = 0;
        while (door_open && ncyc < 20) begin
            ncyc++;
            tick();
        end
        chk("door_len", ncyc, int'(DC));
        chk_all("after_door", 8'h03, 3'd1, 1'b1, 2'd3, 1'b0, 1'b0);

        // Reset mid-door with two entries abandons the stop; later arrive is ignored.
        drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b1); tick();
        chk_all("door_tail2", 8'h0B, 3'd2, 1'b0, 2'd3, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        chk_all("rst_in_door", 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1); tick();
        chk_all("arrive_idle", 8'h00, 3'd0, 1'b0, 2'd0, 1'b0, 1'b0);

        // Random traffic against the reference model.
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0); tick();
        model_step(1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
        for (int c = 0; c < 3000; c++) begin
            logic r, b, d, a;
            logic [1:0] l;
            r = ($urandom_range(199) == 0);
            b = ($urandom_range(9) < 4);
            l = 2'($urandom_range(3));
            d = 1'b0;
            foreach (mq[i]) if (mq[i] == int'(l)) d = 1'b1;
            if ($urandom_range(9) == 0) d = 1'($urandom_range(1));
            a = ($urandom_range(9) < 3);
            drive(r, b, l, d, a);
            tick();
            model_step(r, b, l, d, a);
            model_check($sformatf("rnd%0d", c));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
